// File: rtl/arbitro_som_if.sv
// Channel bus between the requesters and the note arbiter.
interface arbitro_som_if;
    logic [2:0] req;
    logic [2:0] nota_status;
    logic [2:0] nota_botao;
    logic [2:0] nota_memoria;
    logic       cancela;
    logic [2:0] ack;
    logic [2:0] done;
    logic [2:0] grant;
    logic [2:0] arduino_out;
    logic       busy;
    logic [1:0] db_estado;

    // Requester side: drives requests and notes, observes the arbiter
    modport master (
        output req, nota_status, nota_botao, nota_memoria, cancela,
        input  ack, done, grant, arduino_out, busy, db_estado
    );

    // Arbiter side
    modport slave (
        input  req, nota_status, nota_botao, nota_memoria, cancela,
        output ack, done, grant, arduino_out, busy, db_estado
    );
endinterface

// File: rtl/arbitro_som.sv
// Non-preemptive fixed-priority arbiter for the single Arduino sound channel.
// Each grant plays one latched note for NOTE_CYCLES, then GAP_CYCLES of silence.
module arbitro_som #(
    parameter int unsigned NOTE_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 5000000
) (
    input  logic          clock,
    input  logic          reset,
    arbitro_som_if.slave  io_bus
);

    localparam int unsigned CNT_W = 26;
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_TOCA  = 2'b01,
        S_PAUSA = 2'b10
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_ack;
    logic [2:0]       r_done;
    logic [2:0]       r_grant;
    logic [2:0]       r_out;
    logic             r_busy;
    logic [1:0]       r_db;

    logic [2:0]       w_winner;
    logic [2:0]       w_note;

    // Fixed priority pick: status jingle > button feedback > memory playback
    always_comb begin
        w_winner = 3'b000;
        w_note   = 3'b000;
        if (io_bus.req[2]) begin
            w_winner = 3'b100;
            w_note   = io_bus.nota_status;
        end else if (io_bus.req[1]) begin
            w_winner = 3'b010;
            w_note   = io_bus.nota_botao;
        end else if (io_bus.req[0]) begin
            w_winner = 3'b001;
            w_note   = io_bus.nota_memoria;
        end
    end

    // Channel FSM with registered outputs; counter restarts on every state entry
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 3'b000;
            r_done  <= 3'b000;
            r_grant <= 3'b000;
            r_out   <= 3'b000;
            r_busy  <= 1'b0;
            r_db    <= 2'b00;
        end else begin
            r_ack  <= 3'b000;
            r_done <= 3'b000;
            case (r_state)
                S_IDLE: begin
                    if (|io_bus.req) begin
                        r_state <= S_TOCA;
                        r_cnt   <= '0;
                        r_ack   <= w_winner;
                        r_grant <= w_winner;
                        r_out   <= w_note;
                        r_busy  <= 1'b1;
                        r_db    <= 2'b01;
                    end
                end
                S_TOCA: begin
                    // cancela cuts the note short but the gap is still full length
                    if (io_bus.cancela || (r_cnt == NOTE_LAST)) begin
                        r_state <= S_PAUSA;
                        r_cnt   <= '0;
                        r_out   <= 3'b000;
                        r_db    <= 2'b10;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_PAUSA: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_done  <= r_grant;
                        r_grant <= 3'b000;
                        r_busy  <= 1'b0;
                        r_db    <= 2'b00;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean IDLE
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_grant <= 3'b000;
                    r_out   <= 3'b000;
                    r_busy  <= 1'b0;
                    r_db    <= 2'b00;
                end
            endcase
        end
    end

    assign io_bus.ack         = r_ack;
    assign io_bus.done        = r_done;
    assign io_bus.grant       = r_grant;
    assign io_bus.arduino_out = r_out;
    assign io_bus.busy        = r_busy;
    assign io_bus.db_estado   = r_db;

endmodule

// File: tb/tb_arbitro_som.sv
// Bench for arbitro_som: directed scenarios plus random traffic, checked every
// cycle against a transaction timeline model (cycles elapsed since grant).
module tb_arbitro_som;

    localparam int NOTE = 4;
    localparam int GAP  = 2;

    logic clock = 1'b0;
    logic reset;

    arbitro_som_if bus ();

    arbitro_som #(
        .NOTE_CYCLES(NOTE),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io_bus(bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: one transaction = note of m_len cycles + GAP cycles,
    // indexed by m_k = cycles since the grant edge.
    logic       m_active;
    int         m_k;
    int         m_len;
    logic [2:0] m_owner;
    logic [2:0] m_note;

    logic [2:0] e_ack, e_done, e_grant, e_out;
    logic       e_busy;
    logic [1:0] e_db;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (check %0d)", tag, obs, exp, checks);
        end
    endtask

    task automatic set_idle_exp();
        e_grant = 3'b000;
        e_out   = 3'b000;
        e_busy  = 1'b0;
        e_db    = 2'b00;
    endtask

    // Check the current cycle, drive the next inputs, predict the next cycle.
    task automatic step(input logic rst, input logic [2:0] rq, input logic [2:0] ns,
                        input logic [2:0] nb, input logic [2:0] nm, input logic cn);
        @(negedge clock);
        chk("ack",         32'(bus.ack),         32'(e_ack));
        chk("done",        32'(bus.done),        32'(e_done));
        chk("grant",       32'(bus.grant),       32'(e_grant));
        chk("arduino_out", 32'(bus.arduino_out), 32'(e_out));
        chk("busy",        32'(bus.busy),        32'(e_busy));
        chk("db_estado",   32'(bus.db_estado),   32'(e_db));

        reset            = rst;
        bus.req          = rq;
        bus.nota_status  = ns;
        bus.nota_botao   = nb;
        bus.nota_memoria = nm;
        bus.cancela      = cn;

        e_ack  = 3'b000;
        e_done = 3'b000;
        if (rst) begin
            m_active = 1'b0;
            set_idle_exp();
        end else if (m_active) begin
            if (m_k < m_len && cn) m_len = m_k + 1;
            m_k++;
            if (m_k == m_len + GAP) begin
                m_active = 1'b0;
                e_done   = m_owner;
                set_idle_exp();
            end else begin
                e_grant = m_owner;
                e_busy  = 1'b1;
                e_out   = (m_k < m_len) ? m_note : 3'b000;
                e_db    = (m_k < m_len) ? 2'b01 : 2'b10;
            end
        end else if (rq != 3'b000) begin
            m_owner  = rq[2] ? 3'b100 : (rq[1] ? 3'b010 : 3'b001);
            m_note   = rq[2] ? ns : (rq[1] ? nb : nm);
            m_active = 1'b1;
            m_k      = 0;
            m_len    = NOTE;
            e_ack    = m_owner;
            e_grant  = m_owner;
            e_out    = m_note;
            e_busy   = 1'b1;
            e_db     = 2'b01;
        end else begin
            set_idle_exp();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.req          = 3'b000;
        bus.nota_status  = 3'b000;
        bus.nota_botao   = 3'b000;
        bus.nota_memoria = 3'b000;
        bus.cancela      = 1'b0;
        @(posedge clock);
        @(posedge clock);
        m_active = 1'b0;
        e_ack    = 3'b000;
        e_done   = 3'b000;
        set_idle_exp();

        // Reset held, request ignored; reset state checked
        step(1'b1, 3'b111, 3'b011, 3'b010, 3'b001, 1'b1);
        step(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

        // Single memory note 101
        step(1'b0, 3'b001, 3'b000, 3'b000, 3'b101, 1'b0);
        idle(10);

        // All request together: status wins, then button
        step(1'b0, 3'b111, 3'b011, 3'b010, 3'b101, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 3'b011, 3'b011, 3'b010, 3'b101, 1'b0);
        idle(10);

        // Higher priority arrives mid-note and must wait
        step(1'b0, 3'b001, 3'b000, 3'b000, 3'b001, 1'b0);
        step(1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 3'b100, 3'b110, 3'b000, 3'b001, 1'b0);
        idle(10);

        // Cancel during the 2nd note cycle
        step(1'b0, 3'b001, 3'b000, 3'b000, 3'b110, 1'b0);
        step(1'b0, 3'b000, 3'b000, 3'b000, 3'b110, 1'b0);
        step(1'b0, 3'b000, 3'b000, 3'b000, 3'b110, 1'b1);
        idle(8);

        // Reset during the 3rd note cycle, overriding req and cancela
        step(1'b0, 3'b010, 3'b000, 3'b111, 3'b000, 1'b0);
        step(1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0);
        step(1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0);
        step(1'b1, 3'b111, 3'b001, 3'b111, 3'b010, 1'b1);
        idle(8);

        // Note code changes mid-note are ignored
        step(1'b0, 3'b010, 3'b000, 3'b110, 3'b000, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0);

        // Silent note is still fully timed; cancel in the gap is ignored
        step(1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        step(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
        idle(4);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic       r_rst;
            logic [2:0] r_rq;
            logic       r_cn;
            r_rst = ($urandom_range(0, 96) == 0);
            r_rq  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            r_cn  = ($urandom_range(0, 7) == 0);
            step(r_rst, r_rq, 3'($urandom), 3'($urandom), 3'($urandom), r_cn);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
